// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and sends 8N1 frames, LSB first, on Tx.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int BIT_CYCLES = 868,
  parameter int DATA_BITS  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  output logic                 Tx,
  input  logic [DATA_BITS-1:0] DataIn,
  output logic                 ReadEnable,
  input  logic                 Empty,
  output logic                 Busy
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  logic parity;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

  assign bit_end = (cnt == LAST_CNT);

  // Frame sequencer; every output is driven from this register stage.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      Tx         <= 1'b1;
      ReadEnable <= 1'b0;
      Busy       <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (!Empty) begin
            state      <= READ;
            ReadEnable <= 1'b1;
            Busy       <= 1'b1;
          end else begin
            ReadEnable <= 1'b0;
            Busy       <= 1'b0;
          end
        end
        READ: begin
          ReadEnable <= 1'b0;
          state      <= WAIT;
        end
        // FIFO data is valid here, one cycle after the pop strobe.
        WAIT: begin
          shift <= DataIn;
`ifdef UART_TX_PARITY_EN
          parity <= even_parity(DataIn);
`endif
          Tx    <= 1'b0;
          cnt   <= '0;
          state <= START;
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            Tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shift <= shift >> 1;
            if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              Tx    <= parity;
              state <= PARITY;
`else
              Tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
              Tx  <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            Tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            Tx    <= 1'b1;
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          Tx         <= 1'b1;
          ReadEnable <= 1'b0;
          Busy       <= 1'b0;
          cnt        <= '0;
          idx        <= '0;
        end
      endcase
    end
  end

endmodule
